itch_lane_dispatch_scheduler: RTL

- Shares one downstream ITCH payload decoder bank between two feed lanes (primary/backup line handlers).
- Buffers one 512-bit payload per lane and arbitrates round-robin. Filters unsupported message types, then issues single-cycle valid pulses with the payload to the decoders.
- Sits between the lane framers and the add-order/delete/execute decoders. Provides enable/drain sequencing and statistics counters.

---
 rtl/itch_lane_dispatch_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/itch_lane_dispatch_scheduler.sv
// itch_lane_dispatch_scheduler
// Shares one ITCH payload decoder bank between two feed lanes. Each lane has
// a single 512-bit hold register. Held payloads are granted round-robin, and
// unsupported message types are filtered out. Forwarded payloads go to the
// decoders as one-cycle valid pulses. Enable/drain sequencing and saturating
// statistics counters are included.
// Optional feature macro: SEQ_TAG_EN adds a 16-bit issue index (dec_seq).
module itch_lane_dispatch_scheduler #(
    parameter int         CNT_W     = 16,
    parameter logic [4:0] TYPE_MASK = 5'b11111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [511:0]     in0_payload,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [511:0]     in1_payload,
    input  logic             dec_stall,
    output logic             dec_valid,
    output logic [511:0]     dec_payload,
    output logic             dec_lane,
    output logic             idle,
    output logic [CNT_W-1:0] acc_cnt0,
    output logic [CNT_W-1:0] acc_cnt1,
    output logic [CNT_W-1:0] drop_cnt
`ifdef SEQ_TAG_EN
    ,
    output logic [15:0]      dec_seq
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t         state;
    state_t         state_next;
    logic [511:0]   hold0;
    logic [511:0]   hold1;
    logic           hold_v0;
    logic           hold_v1;
    logic           rr;
    logic           grant_any;
    logic           grant0;
    logic           grant1;
    logic [511:0]   grant_payload;
    logic           grant_fwd;
    logic           accept0;
    logic           accept1;

    // Maps the ITCH message type byte onto its forwarding-enable bit; unknown types never forward
    function automatic logic type_enabled(input logic [7:0] msg_type);
        case (msg_type)
            8'h41:   return TYPE_MASK[0];
            8'h44:   return TYPE_MASK[1];
            8'h45:   return TYPE_MASK[2];
            8'h58:   return TYPE_MASK[3];
            8'h55:   return TYPE_MASK[4];
            default: return 1'b0;
        endcase
    endfunction

    // Round-robin grant between the held payloads; rr breaks the tie only when both holds are full
    always_comb begin
        grant_any     = ((state == RUN) || (state == DRAIN)) && !dec_stall && (hold_v0 || hold_v1);
        grant0        = grant_any && hold_v0 && (!hold_v1 || !rr);
        grant1        = grant_any && hold_v1 && (!hold_v0 || rr);
        grant_payload = grant1 ? hold1 : hold0;
        grant_fwd     = type_enabled(grant_payload[511:504]);
    end

    assign in0_ready = (state == RUN) && (!hold_v0 || grant0);
    assign in1_ready = (state == RUN) && (!hold_v1 || grant1);
    assign accept0   = in0_valid && in0_ready;
    assign accept1   = in1_valid && in1_ready;
    assign idle      = (state == IDLE) && !hold_v0 && !hold_v1;

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: drain keeps granting pending holds until both are empty
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold_v0 && !hold_v1) begin
                    state_next = IDLE;
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane hold registers; a reload in the grant cycle wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0   <= '0;
            hold1   <= '0;
            hold_v0 <= 1'b0;
            hold_v1 <= 1'b0;
        end else begin
            if (accept0) begin
                hold0   <= in0_payload;
                hold_v0 <= 1'b1;
            end else if (grant0) begin
                hold_v0 <= 1'b0;
            end
            if (accept1) begin
                hold1   <= in1_payload;
                hold_v1 <= 1'b1;
            end else if (grant1) begin
                hold_v1 <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves to the opposite lane after every grant, forwarded or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (grant0) begin
            rr <= 1'b1;
        end else if (grant1) begin
            rr <= 1'b0;
        end
    end

    // Registered issue to the decoders; payload and lane hold their last value between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid   <= 1'b0;
            dec_payload <= '0;
            dec_lane    <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            if (grant_any && grant_fwd) begin
                dec_valid   <= 1'b1;
                dec_payload <= grant_payload;
                dec_lane    <= grant1;
            end
        end
    end

    // Saturating statistics counters; accepts and drops update independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt0 <= '0;
            acc_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept0 && (acc_cnt0 != '1)) begin
                acc_cnt0 <= acc_cnt0 + CNT_ONE;
            end
            if (accept1 && (acc_cnt1 != '1)) begin
                acc_cnt1 <= acc_cnt1 + CNT_ONE;
            end
            if (grant_any && !grant_fwd && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_ONE;
            end
        end
    end

`ifdef SEQ_TAG_EN
    logic [15:0] seq_cnt;

    // Free-running issue index; only forwarded payloads consume an index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt <= 16'd0;
            dec_seq <= 16'd0;
        end else if (grant_any && grant_fwd) begin
            dec_seq <= seq_cnt;
            seq_cnt <= seq_cnt + 16'd1;
        end
    end
`endif

endmodule
